// File: rtl/concat_pkg.sv
// rtl/concat_pkg.sv - shared mode and fill-state encodings for the stream packer
package concat_pkg;

  localparam logic MODE_PACK = 1'b0;
  localparam logic MODE_REPL = 1'b1;

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_FILLING = 1'b1;

endpackage

// File: rtl/concat_stream_packer.sv
// rtl/concat_stream_packer.sv - packs or replicates IN_W-bit stream words into OUT_W-bit words
module concat_stream_packer
  import concat_pkg::*;
#(
  parameter int   IN_W    = 4,
  parameter int   RATIO   = 4,
  parameter logic PAD_BIT = 1'b0,
  localparam int  OUT_W   = IN_W * RATIO,
  localparam int  CNT_W   = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  if (RATIO < 2) begin : g_bad_ratio
    $error("concat_stream_packer: RATIO must be at least 2");
  end
  if (IN_W < 1) begin : g_bad_width
    $error("concat_stream_packer: IN_W must be at least 1");
  end

  logic [0:0]       state;
  logic             mode_q;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_next;
  logic             accept;
  logic             eff_mode;
  logic             is_repl;
  logic             is_last_slot;
  logic             complete;

  // Ready depends only on registered output state, never on in_*.
  assign in_ready     = !out_valid | out_ready;
  assign accept       = in_valid & in_ready;
  assign eff_mode     = (state == ST_EMPTY) ? mode : mode_q;
  assign is_repl      = (eff_mode == MODE_REPL);
  assign is_last_slot = (count == CNT_W'(RATIO - 1));
  assign complete     = accept & !is_repl & (in_last | is_last_slot);

  // Slot 0 sits in the MSBs; each slot loads only when the fill count points at it.
  for (genvar i = 0; i < RATIO; i++) begin : g_slot
    assign acc_next[OUT_W-1-i*IN_W -: IN_W] =
      (accept && !is_repl && (count == CNT_W'(i))) ? in_data
                                                   : acc[OUT_W-1-i*IN_W -: IN_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      mode_q    <= MODE_PACK;
      count     <= '0;
      acc       <= {OUT_W{PAD_BIT}};
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        if (state == ST_EMPTY) begin
          mode_q <= mode;
        end
        if (is_repl) begin
          out_data  <= {RATIO{in_data}};
          out_count <= CNT_W'(RATIO);
          out_valid <= 1'b1;
        end else if (complete) begin
          out_data  <= acc_next;
          out_count <= count + 1'b1;
          out_valid <= 1'b1;
          acc       <= {OUT_W{PAD_BIT}};
          count     <= '0;
          state     <= ST_EMPTY;
        end else begin
          acc   <= acc_next;
          count <= count + 1'b1;
          state <= ST_FILLING;
        end
      end
    end
  end

endmodule

// File: tb/tb_concat_stream_packer.sv
// tb/tb_concat_stream_packer.sv - directed table and randomized model checks for concat_stream_packer
module tb_concat_stream_packer;

  localparam int IN_W  = 4;
  localparam int RATIO = 4;
  localparam int OUT_W = 16;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             out_ready;
  logic             in_ready0, in_ready1;
  logic [OUT_W-1:0] out_data0, out_data1;
  logic [CNT_W-1:0] out_count0, out_count1;
  logic             out_valid0, out_valid1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  concat_stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .PAD_BIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready0), .out_data(out_data0),
    .out_count(out_count0), .out_valid(out_valid0), .out_ready(out_ready)
  );

  concat_stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .PAD_BIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready1), .out_data(out_data1),
    .out_count(out_count1), .out_valid(out_valid1), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a list of collected words and the word on offer to the consumer.
  logic [IN_W-1:0]  m_words[$];
  bit               m_valid;
  logic [OUT_W-1:0] m_data0, m_data1;
  int               m_count;

  function automatic logic [OUT_W-1:0] build(input bit pad);
    logic [OUT_W-1:0] w;
    w = pad ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    for (int k = 0; k < m_words.size(); k++) begin
      w[OUT_W-1-k*IN_W -: IN_W] = m_words[k];
    end
    return w;
  endfunction

  task automatic m_clear();
    m_words.delete();
    m_valid = 0;
    m_data0 = '0;
    m_data1 = '0;
    m_count = 0;
  endtask

  function automatic bit m_rdy();
    return !m_valid || out_ready;
  endfunction

  task automatic model_step();
    bit rdy;
    rdy = m_rdy();
    if (m_valid && out_ready) m_valid = 0;
    if (in_valid && rdy) begin
      if (m_words.size() == 0 && mode == 1'b1) begin
        m_data0 = {RATIO{in_data}};
        m_data1 = {RATIO{in_data}};
        m_count = RATIO;
        m_valid = 1;
      end else begin
        m_words.push_back(in_data);
        if (in_last || m_words.size() == RATIO) begin
          m_data0 = build(1'b0);
          m_data1 = build(1'b1);
          m_count = m_words.size();
          m_valid = 1;
          m_words.delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic md, input logic [IN_W-1:0] d, input logic v,
                       input logic l, input logic o);
    mode = md; in_data = d; in_valid = v; in_last = l; out_ready = o;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, "_ov0"}, out_valid0, m_valid);
    check({tag, "_ov1"}, out_valid1, m_valid);
    if (m_valid) begin
      check({tag, "_d0"}, out_data0, m_data0);
      check({tag, "_d1"}, out_data1, m_data1);
      check({tag, "_cnt"}, out_count0, m_count);
    end
  endtask

  typedef struct {
    logic             md;
    logic [IN_W-1:0]  d;
    logic             v, l, o;
    logic             e_rdy, e_ov;
    logic [OUT_W-1:0] e_d0, e_d1;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic md, input logic [IN_W-1:0] d, input logic v,
                              input logic l, input logic o, input logic er, input logic eo,
                              input logic [OUT_W-1:0] e0, input logic [OUT_W-1:0] e1,
                              input logic [CNT_W-1:0] ec);
    vec_t r;
    r = '{md, d, v, l, o, er, eo, e0, e1, ec};
    return r;
  endfunction

  vec_t tbl[10];

  initial begin
    tbl[0] = mk(1'b0, 4'hA, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 3'd0);
    tbl[1] = mk(1'b0, 4'hB, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 3'd0);
    tbl[2] = mk(1'b0, 4'hC, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 3'd0);
    tbl[3] = mk(1'b0, 4'hD, 1, 0, 1, 1, 1, 16'hABCD, 16'hABCD, 3'd4);
    tbl[4] = mk(1'b1, 4'h6, 1, 0, 1, 1, 1, 16'h6666, 16'h6666, 3'd4);
    tbl[5] = mk(1'b1, 4'h9, 1, 0, 1, 1, 1, 16'h9999, 16'h9999, 3'd4);
    tbl[6] = mk(1'b0, 4'h1, 1, 0, 1, 1, 0, 16'h0000, 16'h0000, 3'd0);
    tbl[7] = mk(1'b1, 4'h2, 1, 1, 1, 1, 1, 16'h1200, 16'h12FF, 3'd2);
    tbl[8] = mk(1'b0, 4'h0, 0, 1, 1, 1, 0, 16'h0000, 16'h0000, 3'd0);
    tbl[9] = mk(1'b1, 4'h3, 0, 0, 0, 1, 0, 16'h0000, 16'h0000, 3'd0);

    rst = 1'b1;
    drive(1'b0, 4'h0, 0, 0, 1);
    m_clear();
    #12;
    check("rst_ov", out_valid0, 1'b0);
    check("rst_data", out_data0, 16'h0000);
    check("rst_cnt", out_count0, 3'd0);
    check("rst_rdy", in_ready0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed table: pack, replicate, flush with padding, idle in_last
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].md, tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].o);
      #1;
      check($sformatf("tbl%0d_rdy", i), in_ready0, tbl[i].e_rdy);
      tick();
      check($sformatf("tbl%0d_ov", i), out_valid0, tbl[i].e_ov);
      if (tbl[i].e_ov) begin
        check($sformatf("tbl%0d_d0", i), out_data0, tbl[i].e_d0);
        check($sformatf("tbl%0d_d1", i), out_data1, tbl[i].e_d1);
        check($sformatf("tbl%0d_cnt", i), out_count0, tbl[i].e_cnt);
      end
      cmp_model($sformatf("tbl%0d", i));
    end

    // Backpressure: hold ABCD for 5 cycles, then release and accept the waiting word
    drive(1'b0, 4'hA, 1, 0, 1); tick();
    drive(1'b0, 4'hB, 1, 0, 1); tick();
    drive(1'b0, 4'hC, 1, 0, 1); tick();
    drive(1'b0, 4'hD, 1, 0, 0); tick();
    check("bp_ov", out_valid0, 1'b1);
    check("bp_d", out_data0, 16'hABCD);
    drive(1'b0, 4'hE, 1, 0, 0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_rdy", c), in_ready0, 1'b0);
      tick();
      check($sformatf("bp%0d_ov", c), out_valid0, 1'b1);
      check($sformatf("bp%0d_d", c), out_data0, 16'hABCD);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", in_ready0, 1'b1);
    tick();
    check("bp_rel_ov", out_valid0, 1'b0);
    drive(1'b0, 4'hF, 1, 0, 1); tick();
    drive(1'b0, 4'h1, 1, 0, 1); tick();
    drive(1'b0, 4'h2, 1, 0, 1); tick();
    check("bp_next_ov", out_valid0, 1'b1);
    check("bp_next_d", out_data0, 16'hEF12);
    cmp_model("bp");

    // Reset mid-word discards the partial word
    drive(1'b0, 4'h3, 1, 0, 1); tick();
    drive(1'b0, 4'h4, 1, 0, 1); tick();
    drive(1'b0, 4'h0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_ov", out_valid0, 1'b0);
    check("mrst_cnt", out_count0, 3'd0);
    check("mrst_rdy", in_ready0, 1'b1);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 4'h5, 1, 0, 1); tick();
    drive(1'b0, 4'h6, 1, 0, 1); tick();
    drive(1'b0, 4'h7, 1, 0, 1); tick();
    drive(1'b0, 4'h8, 1, 0, 1); tick();
    check("mrst_ov2", out_valid0, 1'b1);
    check("mrst_d", out_data0, 16'h5678);
    check("mrst_cnt2", out_count0, 3'd4);

    // Throughput with the mode pin toggling while filling
    for (int i = 0; i < 8; i++) begin
      drive((i % 4 == 0) ? 1'b0 : logic'(i % 2), 4'(i), 1, 0, 1);
      #1;
      check($sformatf("tp%0d_rdy", i), in_ready0, 1'b1);
      tick();
      if (i == 3) check("tp_w0", out_data0, 16'h0123);
      if (i == 7) check("tp_w1", out_data0, 16'h4567);
      check($sformatf("tp%0d_ov", i), out_valid0, (i % 4 == 3) ? 1'b1 : 1'b0);
      cmp_model($sformatf("tp%0d", i));
    end

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(99) == 0) begin
        drive(1'b0, 4'h0, 0, 0, 0);
        #2;
        rst = 1'b1;
        m_clear();
        #1;
        check($sformatf("rnd%0d_rst_ov", n), out_valid0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        drive(logic'($urandom_range(1)), 4'($urandom), logic'($urandom_range(9) < 7),
              logic'($urandom_range(3) == 0), logic'($urandom_range(9) < 7));
        #1;
        check($sformatf("rnd%0d_rdy0", n), in_ready0, m_rdy());
        check($sformatf("rnd%0d_rdy1", n), in_ready1, m_rdy());
        tick();
        cmp_model($sformatf("rnd%0d", n));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
